hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit for a five-stage pipeline.
//
// Purpose:
//   Combinational operand forwarding for Execute and the Decode branch
//   comparator. Load-use and branch stall detection. Memory-wait stalls
//   driven by a small RUN/WAIT/ERR state machine with a timeout that
//   latches a sticky MemErr.
//
// Ports:
//   CLK, RST_N                    clock (rising edge), async active-low reset
//   RsD, RtD, RsE, RtE            source registers in Decode / Execute
//   WriteRegE/M/W, RegWriteE/M/W  destination register and write enable per stage
//   MemtoRegE, MemtoRegM          load in Execute / Memory
//   BranchD, PCSrcD               branch in Decode / branch taken
//   MemReqM, MemAckM              data-memory request / completion in Memory
//   StallF/D/E/M                  hold the matching pipeline register
//   FlushD, FlushE                clear the Decode / Execute register
//   BubbleW                       suppress write-back
//   ForwardAE/BE                  00 regfile, 01 WB result, 10 ALUOut_M
//   ForwardAD/BD                  Decode comparator takes ALUOut_M
//   MemErr                        sticky memory-timeout error (registered)
//   StallCnt, FlushCnt            performance counters (HAZARD_PERF_CNT_EN only)
//
// Configuration macro: HAZARD_PERF_CNT_EN adds the StallCnt/FlushCnt counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
`endif
  output logic             MemErr
);

  // The wait counter only has to reach MEM_TIMEOUT-1 before leaving WAIT.
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lwstall, brstall, memstall;

  // Forwarding: the Memory stage is younger than Write-back, so it wins.
  // Register 0 is hard-wired to zero and is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ForwardAE = 2'b01;
    if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ForwardBE = 2'b01;
  end

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

  assign lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign brstall = BranchD &&
                   ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  // A request acknowledged in the same cycle never stalls; ERR stalls forever.
  assign memstall = (MemReqM && !MemAckM && state_q != ERR) || (state_q == ERR);

  // Memory-wait FSM. The counter restarts at zero on entry to WAIT and
  // freezes once ERR is reached; an ack in the last WAIT cycle still wins.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (MemReqM && !MemAckM) state_d = WAIT;
      end
      WAIT: begin
        if (MemAckM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // Sampling the registered state delays MemErr one cycle past ERR entry.
    mem_err_d = mem_err_q || (state_q == ERR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign MemErr = mem_err_q;

  // Stall/flush priority: memory wait, then load-use/branch, then taken branch.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleW = 1'b0;
    if (memstall) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
      BubbleW = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcD) begin
      FlushD = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters; they wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF)           stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD || FlushE) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table-driven combinational vectors, hand-written
// multi-cycle sequences for the memory wait / timeout / reset cases, and a
// randomized run against a behavioural reference model.
module tb_hazard_ctrl;

  localparam int MemTimeoutTb = 4;
  localparam int CntWTb       = 4;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD, pcSrcD, memReq, memAck;
  } in_t;

  typedef struct packed {
    logic       stallF, stallD, stallE, stallM, flushD, flushE, bubbleW;
    logic [1:0] fwdAE, fwdBE;
    logic       fwdAD, fwdBD;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic CLK, RST_N;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcD, MemReqM, MemAckM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [CntWTb-1:0] StallCnt, FlushCnt;
`endif

  int checks = 0;
  int failures = 0;

  // reference-model state for the memory handshake
  bit waiting;
  int waitAge;
  int errAge;
  logic [CntWTb-1:0] expStallCnt, expFlushCnt;

  hazard_ctrl #(.MEM_TIMEOUT(MemTimeoutTb), .CNT_W(CntWTb)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleW(BubbleW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .MemErr(MemErr)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // drive every DUT input from one stimulus record
  task automatic applyStimulus(input in_t v);
    RsD = v.rsD; RtD = v.rtD; RsE = v.rsE; RtE = v.rtE;
    WriteRegE = v.wrE; WriteRegM = v.wrM; WriteRegW = v.wrW;
    RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
    MemtoRegE = v.m2rE; MemtoRegM = v.m2rM;
    BranchD = v.brD; PCSrcD = v.pcSrcD; MemReqM = v.memReq; MemAckM = v.memAck;
  endtask

  function automatic out_t dutOut();
    out_t a;
    a.stallF = StallF; a.stallD = StallD; a.stallE = StallE; a.stallM = StallM;
    a.flushD = FlushD; a.flushE = FlushE; a.bubbleW = BubbleW;
    a.fwdAE = ForwardAE; a.fwdBE = ForwardBE; a.fwdAD = ForwardAD; a.fwdBD = ForwardBD;
    return a;
  endfunction

  // compare all hazard outputs plus MemErr against the required values
  task automatic checkOutput(input string name, input out_t exp, input logic expErr);
    out_t act;
    act = dutOut();
    checks++;
    if (act !== exp || MemErr !== expErr) begin
      failures++;
      $display("[TB] FAIL %s: got outs=%b MemErr=%b, expected outs=%b MemErr=%b",
               name, act, MemErr, exp, expErr);
    end
  endtask

  task automatic checkPerf(input string name);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (StallCnt !== expStallCnt || FlushCnt !== expFlushCnt) begin
      failures++;
      $display("[TB] FAIL %s perf: got StallCnt=%0d FlushCnt=%0d, expected %0d %0d",
               name, StallCnt, FlushCnt, expStallCnt, expFlushCnt);
    end
`else
    if (name.len() < 0) $display("[TB] %s", name);
`endif
  endtask

  // one cycle: drive, sample mid-cycle, advance past the next rising edge
  task automatic stepCheck(input string name, input in_t v, input out_t exp, input logic expErr);
    applyStimulus(v);
    #1;
    checkOutput(name, exp, expErr);
    checkPerf(name);
    @(posedge CLK);
    #1;
    if (exp.stallF) expStallCnt = expStallCnt + 1'b1;
    if (exp.flushD || exp.flushE) expFlushCnt = expFlushCnt + 1'b1;
  endtask

  // async reset pulse inside one cycle; the drop is checked before any clock edge
  task automatic resetDut(input string name);
    RST_N = 1'b0;
    applyStimulus('0);
    waiting = 0; waitAge = 0; errAge = -1;
    expStallCnt = '0; expFlushCnt = '0;
    #1;
    checkOutput(name, '0, 1'b0);
    checkPerf(name);
    #2;
    RST_N = 1'b1;
  endtask

  // behavioural reference: forwarding picks the youngest producing stage,
  // then stall/flush follow the fixed priority order
  function automatic logic [1:0] refFwdE(input in_t v, input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (v.rwM && v.wrM == src) return 2'b10;
    if (v.rwW && v.wrW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t refModel(input in_t v, input bit inErr);
    out_t e = '0;
    bit lw, br, mem;
    e.fwdAE = refFwdE(v, v.rsE);
    e.fwdBE = refFwdE(v, v.rtE);
    e.fwdAD = (v.rsD != 0) && v.rwM && (v.wrM == v.rsD);
    e.fwdBD = (v.rtD != 0) && v.rwM && (v.wrM == v.rtD);
    lw  = v.m2rE && (v.rtE == v.rsD || v.rtE == v.rtD);
    br  = v.brD && ((v.rwE && (v.wrE == v.rsD || v.wrE == v.rtD)) ||
                    (v.m2rM && (v.wrM == v.rsD || v.wrM == v.rtD)));
    mem = inErr || (v.memReq && !v.memAck);
    if (mem) begin
      e.stallF = 1; e.stallD = 1; e.stallE = 1; e.stallM = 1; e.bubbleW = 1;
    end else if (lw || br) begin
      e.stallF = 1; e.stallD = 1; e.flushE = 1;
    end else if (v.pcSrcD) begin
      e.flushD = 1;
    end
    return e;
  endfunction

  // advance the memory-handshake model by one clock edge
  task automatic modelStep(input in_t v);
    if (errAge >= 0) begin
      if (errAge < 2) errAge++;
    end else if (waiting) begin
      if (v.memAck) waiting = 0;
      else if (waitAge + 1 >= MemTimeoutTb) begin
        waiting = 0;
        errAge = 0;
      end else waitAge++;
    end else if (v.memReq && !v.memAck) begin
      waiting = 1;
      waitAge = 0;
    end
  endtask

  vec_t tbl[11];
  in_t  lwIn, memIn, curIn;
  out_t memOut, lwOut, expOut;

  initial begin
    RST_N = 1'b0;
    applyStimulus('0);
    @(posedge CLK);
    #1;
    resetDut("reset_state");

    // combinational vectors, all in RUN with no memory request
    for (int k = 0; k < 11; k++) tbl[k] = '0;
    tbl[0].i.rwM = 1; tbl[0].i.wrM = 5; tbl[0].i.rsE = 5; tbl[0].i.rwW = 1; tbl[0].i.wrW = 5;
    tbl[0].o.fwdAE = 2'b10;
    tbl[1].i.rwM = 1; tbl[1].i.wrM = 0; tbl[1].i.rsE = 0; tbl[1].i.rwW = 1; tbl[1].i.wrW = 0;
    tbl[2].i.rwW = 1; tbl[2].i.wrW = 7; tbl[2].i.rtE = 7; tbl[2].i.rwM = 1; tbl[2].i.wrM = 6;
    tbl[2].o.fwdBE = 2'b01;
    tbl[3].i.rwM = 1; tbl[3].i.wrM = 9; tbl[3].i.rsD = 9; tbl[3].i.rtD = 9;
    tbl[3].o.fwdAD = 1; tbl[3].o.fwdBD = 1;
    tbl[4].i.rwM = 0; tbl[4].i.wrM = 4; tbl[4].i.rsE = 4; tbl[4].i.rtE = 4; tbl[4].i.rwW = 1; tbl[4].i.wrW = 4;
    tbl[4].o.fwdAE = 2'b01; tbl[4].o.fwdBE = 2'b01;
    tbl[5].i.m2rE = 1; tbl[5].i.rtE = 8; tbl[5].i.rtD = 8;
    tbl[5].o.stallF = 1; tbl[5].o.stallD = 1; tbl[5].o.flushE = 1;
    tbl[6].i.brD = 1; tbl[6].i.m2rM = 1; tbl[6].i.wrM = 2; tbl[6].i.rtD = 2;
    tbl[6].o.stallF = 1; tbl[6].o.stallD = 1; tbl[6].o.flushE = 1;
    tbl[7].i.brD = 1; tbl[7].i.pcSrcD = 1; tbl[7].i.rsD = 1; tbl[7].i.wrE = 2; tbl[7].i.rwE = 1;
    tbl[7].o.flushD = 1;
    tbl[8].i.brD = 1; tbl[8].i.rwE = 1; tbl[8].i.wrE = 3; tbl[8].i.rsD = 3; tbl[8].i.pcSrcD = 1;
    tbl[8].o.stallF = 1; tbl[8].o.stallD = 1; tbl[8].o.flushE = 1;
    tbl[9].i.m2rE = 1;
    tbl[9].o.stallF = 1; tbl[9].o.stallD = 1; tbl[9].o.flushE = 1;
    tbl[10].i.brD = 1; tbl[10].i.rwE = 0; tbl[10].i.wrE = 3; tbl[10].i.rsD = 3;
    for (int k = 0; k < 11; k++) stepCheck($sformatf("vec%0d", k), tbl[k].i, tbl[k].o, 1'b0);

    // load-use stall for one cycle, then clear
    memOut = '0; memOut.stallF = 1; memOut.stallD = 1; memOut.stallE = 1; memOut.stallM = 1; memOut.bubbleW = 1;
    lwOut = '0; lwOut.stallF = 1; lwOut.stallD = 1; lwOut.flushE = 1;
    lwIn = '0; lwIn.m2rE = 1; lwIn.rtE = 8; lwIn.rsD = 8;
    stepCheck("loaduse_on", lwIn, lwOut, 1'b0);
    curIn = lwIn; curIn.m2rE = 0;
    stepCheck("loaduse_off", curIn, '0, 1'b0);

    // branch hazard hides the taken branch, which shows once the hazard clears
    curIn = tbl[8].i;
    stepCheck("branch_stall", curIn, tbl[8].o, 1'b0);
    curIn.rwE = 0;
    expOut = '0; expOut.flushD = 1;
    stepCheck("branch_taken", curIn, expOut, 1'b0);

    // three-cycle memory wait with a concurrent load-use hazard
    resetDut("reset_before_wait");
    memIn = lwIn; memIn.memReq = 1; memIn.memAck = 0;
    for (int k = 0; k < 3; k++) stepCheck($sformatf("memwait%0d", k), memIn, memOut, 1'b0);
    memIn.memAck = 1;
    stepCheck("memwait_ack", memIn, lwOut, 1'b0);
    stepCheck("after_ack", '0, '0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (StallCnt !== 4 || FlushCnt !== 1) begin
      failures++;
      $display("[TB] FAIL perf_wait_loaduse: got StallCnt=%0d FlushCnt=%0d, expected 4 1", StallCnt, FlushCnt);
    end
`endif
    curIn = '0; curIn.memReq = 1; curIn.memAck = 1;
    stepCheck("req_ack_same_cycle", curIn, '0, 1'b0);
    curIn.memAck = 0;
    stepCheck("run_req_stall", curIn, memOut, 1'b0);
    curIn.memAck = 1;
    stepCheck("run_req_ack", curIn, '0, 1'b0);

    // timeout: one RUN stall cycle plus four WAIT cycles, then ERR
    memIn = '0; memIn.memReq = 1;
    for (int k = 0; k < 5; k++) stepCheck($sformatf("timeout%0d", k), memIn, memOut, 1'b0);
    stepCheck("err_entry", '0, memOut, 1'b0);
    stepCheck("err_memerr", '0, memOut, 1'b1);
    curIn = lwIn; curIn.memReq = 1; curIn.memAck = 1;
    stepCheck("err_sticky", curIn, memOut, 1'b1);
    resetDut("reset_from_err");
    stepCheck("run_after_err", tbl[7].i, tbl[7].o, 1'b0);

    // long stall run wraps the narrow stall counter
    resetDut("reset_before_wrap");
    for (int k = 0; k < 18; k++) stepCheck($sformatf("wrap%0d", k), lwIn, lwOut, 1'b0);
    stepCheck("wrap_done", '0, '0, 1'b0);

    // randomized traffic against the reference model
    resetDut("reset_before_random");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) resetDut($sformatf("rand_reset%0d", n));
      curIn = '0;
      curIn.rsD = 5'($urandom_range(0, 3)); curIn.rtD = 5'($urandom_range(0, 3));
      curIn.rsE = 5'($urandom_range(0, 3)); curIn.rtE = 5'($urandom_range(0, 3));
      curIn.wrE = 5'($urandom_range(0, 3)); curIn.wrM = 5'($urandom_range(0, 3));
      curIn.wrW = 5'($urandom_range(0, 3));
      curIn.rwE = 1'($urandom_range(0, 1)); curIn.rwM = 1'($urandom_range(0, 1));
      curIn.rwW = 1'($urandom_range(0, 1)); curIn.m2rE = 1'($urandom_range(0, 1));
      curIn.m2rM = 1'($urandom_range(0, 1)); curIn.brD = 1'($urandom_range(0, 1));
      curIn.pcSrcD = 1'($urandom_range(0, 1));
      curIn.memReq = ($urandom_range(0, 2) == 0);
      curIn.memAck = 1'($urandom_range(0, 1));
      expOut = refModel(curIn, errAge >= 0);
      stepCheck($sformatf("rand%0d", n), curIn, expOut, errAge >= 1);
      modelStep(curIn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
